uart_rx: RTL and testbench

Asynchronous serial receiver for the MAX10 board top. It sits directly downstream of the `RXD` pin, which the host-side bench UART model drives at 115200 baud, 8N1. It deserialises each frame and buffers the received bytes in a small FIFO. The core's UART peripheral drains the FIFO through a valid/ready handshake.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_fifo.sv | 50 +++++
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: receiver FSM states and baud divisor helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Clock cycles per bit, truncated; shared with the transmitter.
    function automatic int unsigned uart_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with valid/ready read side and full status; head entry read combinationally.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    input  logic             ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop;
    logic             wr_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid = (wr_ptr != rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign pop   = valid && ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop input synchroniser, mid-bit sampling FSM and receive FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 48000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DOUT,
    output logic       DOUT_VALID,
    input  logic       DOUT_READY,
    output logic       FRAME_ERR,
    output logic       OVERRUN
);

    localparam int unsigned DIV  = uart_div(CLK_FREQ, BAUD);
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV);

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic      rx_meta;
    logic      rx_s;
    rx_state_t state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    sh;
    logic          sample;
    logic          push;
    logic          full;
    logic          pop;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rx_s    <= rx_meta;
        end
    end

    // Push is decoded in the stop-sample cycle so DOUT_VALID rises on the next cycle.
    always_comb begin
        sample = (cnt == '0);
        push   = (state == STOP) && sample && rx_s;
        pop    = DOUT_VALID && DOUT_READY;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            bitn      <= '0;
            sh        <= '0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        cnt   <= HALF_M1;
                        state <= START;
                    end
                end
                START: begin
                    if (sample) begin
                        if (!rx_s) begin
                            cnt   <= DIV_M1;
                            bitn  <= '0;
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DATA: begin
                    if (sample) begin
                        sh  <= {rx_s, sh[7:1]};
                        cnt <= DIV_M1;
                        if (bitn == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bitn <= bitn + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                STOP: begin
                    // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                    if (sample) begin
                        state <= IDLE;
                        if (!rx_s) begin
                            FRAME_ERR <= 1'b1;
                        end else begin
                            OVERRUN <= full && !pop;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data (sh),
        .full      (full),
        .dout      (DOUT),
        .valid     (DOUT_VALID),
        .ready     (DOUT_READY)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: timing, back-to-back, overrun, framing error, glitch, mid-frame reset.
module tb_uart_rx;

    localparam int DIV = 416;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RXD = 1'b1;
    logic [7:0] DOUT;
    logic       DOUT_VALID;
    logic       DOUT_READY = 1'b0;
    logic       FRAME_ERR;
    logic       OVERRUN;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int first_valid = -1;
    int valid_cycles = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    logic [7:0] rxq[$];

    uart_rx #(
        .CLK_FREQ   (48000000),
        .BAUD       (115200),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RXD        (RXD),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .FRAME_ERR  (FRAME_ERR),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!RST) begin
            if (DOUT_VALID && DOUT_READY) rxq.push_back(DOUT);
            if (DOUT_VALID) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (FRAME_ERR) ferr_cnt++;
            if (OVERRUN) ovr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input int i);
        if (i < rxq.size()) return {24'h0, rxq[i]};
        return 'x;
    endfunction

    task automatic clr_mon();
        rxq.delete();
        first_valid  = -1;
        valid_cycles = 0;
        ferr_cnt     = 0;
        ovr_cnt      = 0;
    endtask

    // Caller must be at a negedge; each bit is held for DIV cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        RXD = 1'b0;
        fall_cyc = cyc;
        repeat (DIV) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (DIV) @(negedge CLK);
        end
        RXD = stop;
        repeat (DIV) @(negedge CLK);
        RXD = 1'b1;
    endtask

    initial begin
        logic [7:0] b2b [3];
        b2b[0] = 8'h4F;
        b2b[1] = 8'h4B;
        b2b[2] = 8'h0A;

        #1;
        check("rst_valid", DOUT_VALID, 0);
        check("rst_ferr", FRAME_ERR, 0);
        check("rst_ovr", OVERRUN, 0);
        check("rst_dout", DOUT, 0);
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // Single byte with exact latency
        DOUT_READY = 1'b1;
        clr_mon();
        send_frame(8'h41, 1'b1);
        repeat (10) @(negedge CLK);
        check("single_lat", first_valid - fall_cyc, 3955);
        check("single_vcyc", valid_cycles, 1);
        check("single_cnt", rxq.size(), 1);
        check("single_data", q_at(0), 32'h41);
        check("single_ferr", ferr_cnt, 0);
        check("single_ovr", ovr_cnt, 0);

        // Back-to-back, held then drained one per cycle
        DOUT_READY = 1'b0;
        clr_mon();
        for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b1);
        check("b2b_held_valid", DOUT_VALID, 1);
        check("b2b_head0", DOUT, 32'h4F);
        DOUT_READY = 1'b1;
        @(negedge CLK);
        check("b2b_head1", DOUT, 32'h4B);
        @(negedge CLK);
        check("b2b_head2", DOUT, 32'h0A);
        @(negedge CLK);
        check("b2b_empty", DOUT_VALID, 0);
        check("b2b_cnt", rxq.size(), 3);
        check("b2b_err", ferr_cnt + ovr_cnt, 0);

        // Overrun on the fifth byte
        DOUT_READY = 1'b0;
        clr_mon();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        check("ovr_pulses", ovr_cnt, 1);
        check("ovr_head", DOUT, 32'h01);
        check("ovr_ferr", ferr_cnt, 0);
        DOUT_READY = 1'b1;
        repeat (10) @(negedge CLK);
        check("ovr_cnt", rxq.size(), 4);
        for (int i = 0; i < 4; i++) check("ovr_data", q_at(i), 32'(i + 1));

        // Framing error then a good byte
        clr_mon();
        send_frame(8'h55, 1'b0);
        repeat (2 * DIV) @(negedge CLK);
        check("ferr_pulses", ferr_cnt, 1);
        check("ferr_nopush", rxq.size(), 0);
        check("ferr_ovr", ovr_cnt, 0);
        clr_mon();
        send_frame(8'hAA, 1'b1);
        repeat (10) @(negedge CLK);
        check("ferr_next_cnt", rxq.size(), 1);
        check("ferr_next_data", q_at(0), 32'hAA);
        check("ferr_next_ferr", ferr_cnt, 0);

        // 100-cycle glitch must be ignored
        clr_mon();
        RXD = 1'b0;
        repeat (100) @(negedge CLK);
        RXD = 1'b1;
        repeat (2 * DIV) @(negedge CLK);
        check("glitch_valid", valid_cycles, 0);
        check("glitch_err", ferr_cnt + ovr_cnt, 0);
        send_frame(8'h3C, 1'b1);
        repeat (10) @(negedge CLK);
        check("glitch_next", q_at(0), 32'h3C);

        // Reset during bit 4 with a byte already buffered
        DOUT_READY = 1'b0;
        clr_mon();
        send_frame(8'h77, 1'b1);
        check("prerst_head", DOUT, 32'h77);
        fork
            send_frame(8'h33, 1'b1);
            begin
                repeat (5 * DIV + 200) @(negedge CLK);
                RST = 1'b1;
                #1;
                check("midrst_valid", DOUT_VALID, 0);
                check("midrst_dout", DOUT, 0);
                check("midrst_ferr", FRAME_ERR, 0);
                check("midrst_ovr", OVERRUN, 0);
                repeat (3) @(negedge CLK);
                RST = 1'b0;
            end
        join
        DOUT_READY = 1'b1;
        repeat (8 * DIV) @(negedge CLK);
        clr_mon();
        send_frame(8'h5A, 1'b1);
        repeat (10) @(negedge CLK);
        check("postrst_cnt", rxq.size(), 1);
        check("postrst_data", q_at(0), 32'h5A);
        check("postrst_err", ferr_cnt + ovr_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
